// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - display sequencer selecting ALU result/flag nibbles for the 7-segment decoder
// Static modes show live data; scan modes rotate over a per-frame snapshot paced by prescaler and dwell count.
module seg_scan_mux #(
   parameter int PRESC_W   = 16,
   parameter int PRESC_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] result,
   input  logic [7:0] flags,
   input  logic [2:0] sel,
   input  logic [7:0] dwell,
   output logic [3:0] nibble,
   output logic       dp,
   output logic       blank,
   output logic       lamp_test,
   output logic [1:0] digit_idx,
   output logic       tick
);

   localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(PRESC_DIV - 1);
   localparam logic [2:0]         MODE_SCAN2 = 3'd4;
   localparam logic [2:0]         MODE_SCAN4 = 3'd5;
   localparam logic [2:0]         MODE_BLANK = 3'd6;
   localparam logic [2:0]         MODE_LAMP  = 3'd7;

   logic [2:0]         sel_q, sel_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [7:0]         dwell_cnt_q, dwell_cnt_d;
   logic [1:0]         digit_q, digit_d;
   logic [7:0]         snap_result_q, snap_result_d;
   logic [7:0]         snap_flags_q, snap_flags_d;
   logic [3:0]         nibble_q, nibble_d;
   logic               dp_q, dp_d;
   logic               blank_q, blank_d;
   logic               lamp_q, lamp_d;
   logic               tick_q, tick_d;

   logic mode_chg;
   logic pre_tick;
   logic scan_mode;
   logic advance;
   logic snap_load;

   function automatic logic [3:0] pick(input logic [7:0] r, input logic [7:0] f,
                                       input logic [1:0] i);
      case (i)
         2'd0:    pick = r[3:0];
         2'd1:    pick = r[7:4];
         2'd2:    pick = f[3:0];
         default: pick = f[7:4];
      endcase
   endfunction

   always_comb begin
      mode_chg    = (sel != sel_q);
      pre_tick    = (presc_q == PRESC_MAX);
      scan_mode   = (sel_q == MODE_SCAN2) || (sel_q == MODE_SCAN4);
      sel_d       = sel;
      presc_d     = pre_tick ? '0 : presc_q + PRESC_W'(1);
      dwell_cnt_d = dwell_cnt_q;
      advance     = 1'b0;
      digit_d     = digit_q;

      // Counter wraps through 255 if dwell was lowered below it; that is intended.
      if (pre_tick) begin
         if (dwell_cnt_q == dwell) begin
            dwell_cnt_d = '0;
            advance     = scan_mode;
         end else begin
            dwell_cnt_d = dwell_cnt_q + 8'd1;
         end
      end

      if (advance) begin
         if (sel_q == MODE_SCAN2) digit_d = {1'b0, ~digit_q[0]};
         else                     digit_d = digit_q + 2'd1;
      end

      snap_load = !scan_mode || (advance && (digit_d == 2'd0));

      if (mode_chg) begin
         presc_d     = '0;
         dwell_cnt_d = '0;
         advance     = 1'b0;
         snap_load   = 1'b1;
         if (!sel[2]) digit_d = sel[1:0];
         else         digit_d = 2'd0;
      end

      snap_result_d = snap_load ? result : snap_result_q;
      snap_flags_d  = snap_load ? flags  : snap_flags_q;

      tick_d   = advance;
      nibble_d = 4'h0;
      dp_d     = 1'b0;
      blank_d  = 1'b1;
      lamp_d   = 1'b0;
      // The mode-change edge is shown blank; the new mode appears from the next edge.
      if (!mode_chg) begin
         case (sel_q)
            MODE_BLANK: begin
               blank_d = 1'b1;
            end
            MODE_LAMP: begin
               nibble_d = 4'h8;
               dp_d     = 1'b1;
               blank_d  = 1'b0;
               lamp_d   = 1'b1;
            end
            default: begin
               nibble_d = pick(snap_result_d, snap_flags_d, digit_d);
               dp_d     = digit_d[0];
               blank_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q         <= MODE_BLANK;
         presc_q       <= '0;
         dwell_cnt_q   <= '0;
         digit_q       <= '0;
         snap_result_q <= '0;
         snap_flags_q  <= '0;
         nibble_q      <= '0;
         dp_q          <= 1'b0;
         blank_q       <= 1'b1;
         lamp_q        <= 1'b0;
         tick_q        <= 1'b0;
      end else if (ena) begin
         sel_q         <= sel_d;
         presc_q       <= presc_d;
         dwell_cnt_q   <= dwell_cnt_d;
         digit_q       <= digit_d;
         snap_result_q <= snap_result_d;
         snap_flags_q  <= snap_flags_d;
         nibble_q      <= nibble_d;
         dp_q          <= dp_d;
         blank_q       <= blank_d;
         lamp_q        <= lamp_d;
         tick_q        <= tick_d;
      end
   end

   assign nibble    = nibble_q;
   assign dp        = dp_q;
   assign blank     = blank_q;
   assign lamp_test = lamp_q;
   assign digit_idx = digit_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed bench for seg_scan_mux with a scoreboard of expected digit advances
module tb_seg_scan_mux;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] result;
   logic [7:0] flags;
   logic [2:0] sel;
   logic [7:0] dwell;
   logic [3:0] nibble;
   logic       dp;
   logic       blank;
   logic       lamp_test;
   logic [1:0] digit_idx;
   logic       tick;

   typedef struct {
      logic [3:0] nib;
      logic [1:0] idx;
      int         cyc;
   } adv_t;

   adv_t sb[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   cyc_cnt = 0;
   int   c0, c1, c2, c3;
   logic [9:0] held;

   seg_scan_mux #(.PRESC_W(16), .PRESC_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .result    (result),
      .flags     (flags),
      .sel       (sel),
      .dwell     (dwell),
      .nibble    (nibble),
      .dp        (dp),
      .blank     (blank),
      .lamp_test (lamp_test),
      .digit_idx (digit_idx),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   task automatic tic();
      @(posedge clk);
      #1;
      cyc_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] nib, input logic [1:0] idx, input int cyc);
      adv_t e;
      e.nib = nib;
      e.idx = idx;
      e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic run_scan(input int n);
      adv_t e;
      for (int i = 0; i < n; i++) begin
         tic();
         if (tick === 1'b1) begin
            if (sb.size() == 0) begin
               chk("tick_unexpected", {31'd0, tick}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("adv_cycle", cyc_cnt, e.cyc);
               chk("adv_nibble", {28'd0, nibble}, {28'd0, e.nib});
               chk("adv_digit", {30'd0, digit_idx}, {30'd0, e.idx});
            end
         end
      end
      chk("adv_pending", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      sel    = 3'd0;
      result = 8'h5A;
      flags  = 8'h00;
      dwell  = 8'd1;
      tic();
      tic();
      chk("rst_outs", {nibble, dp, blank, lamp_test, digit_idx, tick}, {4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});
      rst_n = 1'b1;
      tic();
      chk("first_edge_blank", {31'd0, blank}, 32'd1);
      tic();
      chk("first_mode_out", {nibble, blank}, {4'hA, 1'b0});

      // static mode 1
      sel    = 3'd1;
      result = 8'hA5;
      tic();
      tic();
      chk("static1_out", {nibble, dp, digit_idx}, {4'hA, 1'b1, 2'd1});
      result = 8'h3C;
      tic();
      chk("static1_update", {28'd0, nibble}, 32'h3);
      sel   = 3'd3;
      flags = 8'h43;
      tic();
      tic();
      chk("static3_out", {nibble, dp, digit_idx}, {4'h4, 1'b1, 2'd3});

      // scan-all
      result = 8'h21;
      sel    = 3'd5;
      tic();
      c0 = cyc_cnt;
      chk("scan_start_idx", {30'd0, digit_idx}, 32'd0);
      push(4'h2, 2'd1, c0 + 8);
      push(4'h3, 2'd2, c0 + 16);
      push(4'h4, 2'd3, c0 + 24);
      push(4'h1, 2'd0, c0 + 32);
      run_scan(32);

      // snapshot holds across the frame
      result = 8'hF0;
      tic();
      chk("snap_digit0_hold", {28'd0, nibble}, 32'h1);
      push(4'h2, 2'd1, c0 + 40);
      push(4'h3, 2'd2, c0 + 48);
      push(4'h4, 2'd3, c0 + 56);
      push(4'h0, 2'd0, c0 + 64);
      push(4'hF, 2'd1, c0 + 72);
      run_scan(39);

      // ena freeze in mode 4
      sel = 3'd4;
      tic();
      c1 = cyc_cnt;
      push(4'hF, 2'd1, c1 + 8);
      run_scan(12);
      held  = {nibble, dp, blank, lamp_test, digit_idx, tick};
      ena   = 1'b0;
      flags = 8'h99;
      for (int i = 0; i < 10; i++) begin
         tic();
         chk("freeze_hold", {22'd0, nibble, dp, blank, lamp_test, digit_idx, tick}, {22'd0, held});
      end
      ena = 1'b1;
      push(4'h0, 2'd0, c1 + 26);
      push(4'hF, 2'd1, c1 + 34);
      run_scan(12);

      // lamp test and blank
      sel = 3'd7;
      tic();
      tic();
      chk("lamp_outs", {nibble, dp, blank, lamp_test, digit_idx}, {4'h8, 1'b1, 1'b0, 1'b1, 2'd0});
      sel = 3'd6;
      tic();
      tic();
      chk("blank_outs", {nibble, dp, blank, lamp_test}, {4'h0, 1'b0, 1'b1, 1'b0});

      // 5 -> 4 switch on the edge an advance would occur
      result = 8'h21;
      sel    = 3'd5;
      tic();
      c2 = cyc_cnt;
      push(4'h2, 2'd1, c2 + 8);
      run_scan(15);
      sel = 3'd4;
      tic();
      c3 = cyc_cnt;
      chk("switch_no_tick", {31'd0, tick}, 32'd0);
      chk("switch_idx", {30'd0, digit_idx}, 32'd0);
      push(4'h2, 2'd1, c3 + 8);
      run_scan(8);

      // dwell = 0 advances on every prescaler tick
      dwell = 8'd0;
      push(4'h1, 2'd0, c3 + 12);
      push(4'h2, 2'd1, c3 + 16);
      run_scan(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
